// File: rtl/fib_seq_pkg.sv
// Shared types and constants for the Fibonacci term sequencer.
package fib_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

  localparam int FIB_WIDTH_DEFAULT = 8;
  localparam int IDX_W             = 5;

endpackage

// File: rtl/fib_step.sv
// Combinational adder producing the next Fibonacci term and its carry-out.
module fib_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_sequencer.sv
// Fibonacci term generator: loads two seeds, emits one term per non-held RUN
// cycle, and stops on carry-out (sticky overflow) or at the term-index limit.
module fib_sequencer
  import fib_seq_pkg::*;
#(
  parameter int WIDTH      = FIB_WIDTH_DEFAULT,
  parameter int MAX_TERMS  = 24,
  parameter int AUTO_START = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  output logic [WIDTH-1:0] fib_out,
  output logic             fib_valid,
  output logic [IDX_W-1:0] term_idx,
  output logic             overflow,
  output logic             busy,
  output fib_state_e       dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_TERMS - 1);

  // Handshake: fib_valid is a one-cycle push-only strobe; the consumer has no
  // ready and must take fib_out/term_idx in the cycle fib_valid is high.

  fib_state_e       state, state_n;
  logic [WIDTH-1:0] a_q, b_q, a_n, b_n;
  logic [WIDTH-1:0] out_n;
  logic [IDX_W-1:0] idx_n;
  logic             valid_n, ovf_n;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             load;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .a     (a_q),
    .b     (b_q),
    .sum   (sum),
    .carry (carry)
  );

  assign load = ((state == IDLE) && (start || (AUTO_START != 0))) ||
                ((state == DONE) && start);

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    out_n   = fib_out;
    idx_n   = term_idx;
    valid_n = 1'b0;
    ovf_n   = overflow;
    case (state)
      IDLE, DONE: begin
        if (load) begin
          a_n     = seed0;
          b_n     = seed1;
          out_n   = seed0;
          idx_n   = '0;
          valid_n = 1'b1;
          ovf_n   = 1'b0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          out_n   = b_q;
          idx_n   = term_idx + 1'b1;
          valid_n = 1'b1;
          // On carry the seeds stay put: the b just emitted is the final term.
          if (carry) begin
            ovf_n   = 1'b1;
            state_n = DONE;
          end else begin
            a_n = b_q;
            b_n = sum;
          end
          if (idx_n == LAST_IDX) state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      fib_out   <= '0;
      fib_valid <= 1'b0;
      term_idx  <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      a_q       <= a_n;
      b_q       <= b_n;
      fib_out   <= out_n;
      fib_valid <= valid_n;
      term_idx  <= idx_n;
      overflow  <= ovf_n;
      busy      <= (state_n == RUN);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_fib_sequencer.sv
// Scoreboard bench: three sequencer instances (auto-start, short index limit,
// manual start), each with its own expected-term queue and monitor.
module tb_fib_sequencer;
  import fib_seq_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // instance a: defaults (auto-start, 24 terms), optional downstream monitor
  logic       rst_a = 1'b1, start_a = 1'b0, hold_a = 1'b0, mon_en = 1'b0, mon_trip = 1'b0;
  logic [7:0] s0_a = 8'd0, s1_a = 8'd1;
  logic [7:0] out_a; logic val_a, ovf_a, busy_a; logic [4:0] idx_a; fib_state_e st_a;
  logic       dut_rst_a;
  // instance b: index limit 6
  logic       rst_b = 1'b1, start_b = 1'b0, hold_b = 1'b0;
  logic [7:0] s0_b = 8'd1, s1_b = 8'd1;
  logic [7:0] out_b; logic val_b, ovf_b, busy_b; logic [4:0] idx_b; fib_state_e st_b;
  // instance c: manual start
  logic       rst_c = 1'b1, start_c = 1'b0, hold_c = 1'b0;
  logic [7:0] s0_c = 8'd50, s1_c = 8'd60;
  logic [7:0] out_c; logic val_c, ovf_c, busy_c; logic [4:0] idx_c; fib_state_e st_c;

  logic [12:0] exp_a[$];
  logic [12:0] exp_b[$];
  logic [12:0] exp_c[$];

  // downstream monitor: registered compare, resets the sequencer past 128
  always_ff @(posedge clock) mon_trip <= mon_en && (out_a > 8'd128);
  assign dut_rst_a = rst_a | mon_trip;

  fib_sequencer u_a (
    .clock(clock), .reset(dut_rst_a), .start(start_a), .hold(hold_a),
    .seed0(s0_a), .seed1(s1_a), .fib_out(out_a), .fib_valid(val_a),
    .term_idx(idx_a), .overflow(ovf_a), .busy(busy_a), .dbg_state(st_a));

  fib_sequencer #(.MAX_TERMS(6)) u_b (
    .clock(clock), .reset(rst_b), .start(start_b), .hold(hold_b),
    .seed0(s0_b), .seed1(s1_b), .fib_out(out_b), .fib_valid(val_b),
    .term_idx(idx_b), .overflow(ovf_b), .busy(busy_b), .dbg_state(st_b));

  fib_sequencer #(.AUTO_START(0)) u_c (
    .clock(clock), .reset(rst_c), .start(start_c), .hold(hold_c),
    .seed0(s0_c), .seed1(s1_c), .fib_out(out_c), .fib_valid(val_c),
    .term_idx(idx_c), .overflow(ovf_c), .busy(busy_c), .dbg_state(st_c));

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int sel, input int idx, input int val);
    logic [12:0] e;
    e = {idx[4:0], val[7:0]};
    case (sel)
      0:       exp_a.push_back(e);
      1:       exp_b.push_back(e);
      default: exp_c.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return exp_a.size();
      1:       return exp_b.size();
      default: return exp_c.size();
    endcase
  endfunction

  function automatic fib_state_e cur_state(input int sel);
    case (sel)
      0:       return st_a;
      1:       return st_b;
      default: return st_c;
    endcase
  endfunction

  // monitors: pop and compare on every valid strobe
  always @(negedge clock) begin
    logic [12:0] e;
    if (val_a) begin
      if (exp_a.size() == 0) check("a_unexpected_term", out_a, -1);
      else begin
        e = exp_a.pop_front();
        check("a_term_val", out_a, e[7:0]);
        check("a_term_idx", idx_a, e[12:8]);
      end
    end
  end

  always @(negedge clock) begin
    logic [12:0] e;
    if (val_b) begin
      if (exp_b.size() == 0) check("b_unexpected_term", out_b, -1);
      else begin
        e = exp_b.pop_front();
        check("b_term_val", out_b, e[7:0]);
        check("b_term_idx", idx_b, e[12:8]);
      end
    end
  end

  always @(negedge clock) begin
    logic [12:0] e;
    if (val_c) begin
      if (exp_c.size() == 0) check("c_unexpected_term", out_c, -1);
      else begin
        e = exp_c.pop_front();
        check("c_term_val", out_c, e[7:0]);
        check("c_term_idx", idx_c, e[12:8]);
      end
    end
  end

  task automatic wait_done(input int sel, input int budget, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clock);
      ok = (qsize(sel) == 0) && (cur_state(sel) == DONE);
    end
    check(name, int'(ok), 1);
  endtask

  task automatic wait_empty(input int sel, input int budget, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clock);
      ok = (qsize(sel) == 0);
    end
    check(name, int'(ok), 1);
  endtask

  task automatic wait_term_a(input int val, input int budget, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clock);
      ok = val_a && (out_a == val[7:0]);
    end
    check(name, int'(ok), 1);
  endtask

  task automatic pulse_start_c();
    start_c = 1'b1;
    @(negedge clock);
    start_c = 1'b0;
  endtask

  // hand-computed Fibonacci terms from seeds 0/1 in 8 bits
  int fib01[14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clock);
    check("a_rst_out", out_a, 0);
    check("a_rst_valid", val_a, 0);
    check("a_rst_idx", idx_a, 0);
    check("a_rst_ovf", ovf_a, 0);
    check("a_rst_busy", busy_a, 0);
    check("a_rst_state", st_a, IDLE);

    // auto-start: full 0/1 sequence to overflow
    for (int i = 0; i < 14; i++) push(0, i, fib01[i]);
    rst_a = 1'b0;
    wait_done(0, 40, "a_auto_done");
    check("a_auto_ovf", ovf_a, 1);
    check("a_auto_idx", idx_a, 13);
    check("a_auto_out", out_a, 233);
    check("a_auto_busy", busy_a, 0);
    repeat (3) @(negedge clock);
    check("a_done_stays", cur_state(0), DONE);
    check("a_done_idx", idx_a, 13);

    // hold for three cycles after term 5
    rst_a = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 6; i++) push(0, i, fib01[i]);
    rst_a = 1'b0;
    wait_term_a(5, 20, "a_hold_reach5");
    hold_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("a_hold_valid", val_a, 0);
      check("a_hold_out", out_a, 5);
      check("a_hold_idx", idx_a, 5);
      check("a_hold_busy", busy_a, 1);
    end
    for (int i = 6; i < 14; i++) push(0, i, fib01[i]);
    hold_a = 1'b0;
    wait_done(0, 30, "a_hold_done");

    // mid-sequence reset at term 21
    rst_a = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 9; i++) push(0, i, fib01[i]);
    rst_a = 1'b0;
    wait_term_a(21, 30, "a_mid_reach21");
    rst_a = 1'b1;
    #1;
    check("a_mid_out", out_a, 0);
    check("a_mid_valid", val_a, 0);
    check("a_mid_idx", idx_a, 0);
    check("a_mid_busy", busy_a, 0);
    check("a_mid_state", st_a, IDLE);
    @(negedge clock);
    check("a_mid_qempty", exp_a.size(), 0);
    for (int i = 0; i < 14; i++) push(0, i, fib01[i]);
    rst_a = 1'b0;
    wait_done(0, 40, "a_mid_restart_done");

    // downstream monitor resets at 144; sequence repeats
    rst_a = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 13; i++) push(0, i, fib01[i]);
    rst_a = 1'b0;
    wait_empty(0, 80, "a_mon_two_laps");
    rst_a = 1'b1;
    mon_en = 1'b0;

    // index limit 6, seeds 1/1
    push(1, 0, 1); push(1, 1, 1); push(1, 2, 2);
    push(1, 3, 3); push(1, 4, 5); push(1, 5, 8);
    @(negedge clock);
    rst_b = 1'b0;
    wait_done(1, 20, "b_limit_done");
    check("b_limit_idx", idx_b, 5);
    check("b_limit_ovf", ovf_b, 0);
    check("b_limit_out", out_b, 8);
    check("b_limit_busy", busy_b, 0);
    repeat (3) @(negedge clock);
    check("b_done_stays", cur_state(1), DONE);

    // manual start: idle until start; start in RUN ignored
    rst_c = 1'b0;
    repeat (4) @(negedge clock);
    check("c_idle_state", st_c, IDLE);
    check("c_idle_busy", busy_c, 0);
    push(2, 0, 50); push(2, 1, 60); push(2, 2, 110); push(2, 3, 170);
    pulse_start_c();
    s0_c = 8'd100;
    s1_c = 8'd100;
    pulse_start_c();
    wait_done(2, 20, "c_first_done");
    check("c_first_idx", idx_c, 3);
    check("c_first_ovf", ovf_c, 1);
    check("c_first_out", out_c, 170);

    // hold has no effect in DONE
    hold_c = 1'b1;
    repeat (2) @(negedge clock);
    check("c_hold_done_state", st_c, DONE);
    check("c_hold_done_out", out_c, 170);
    check("c_hold_done_idx", idx_c, 3);
    hold_c = 1'b0;

    // restart from DONE with seeds 100/100
    push(2, 0, 100); push(2, 1, 100); push(2, 2, 200);
    pulse_start_c();
    check("c_restart_ovf_clr", ovf_c, 0);
    check("c_restart_busy", busy_c, 1);
    wait_done(2, 20, "c_restart_done");
    check("c_restart_ovf", ovf_c, 1);
    check("c_restart_idx", idx_c, 2);
    check("c_restart_out", out_c, 200);

    repeat (2) @(negedge clock);
    check("a_q_final", exp_a.size(), 0);
    check("b_q_final", exp_b.size(), 0);
    check("c_q_final", exp_c.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
